// File: rtl/memory_sram_pkg.sv
// Shared definitions for the parametrised single-port SRAM model:
// sequencer state codes, legal read latencies and parameter legality check.
package memory_sram_pkg;

    typedef enum logic {
        MEM_STATE_CLEAR = 1'b0,
        MEM_STATE_READY = 1'b1
    } mem_state_e;

    localparam int unsigned READ_LATENCY_MIN = 1;
    localparam int unsigned READ_LATENCY_MAX = 2;

    // True when the word splits evenly into lanes and the latency is supported.
    function automatic bit params_legal(input int unsigned data_width,
                                        input int unsigned byte_width,
                                        input int unsigned read_latency);
        return (byte_width != 0) && ((data_width % byte_width) == 0) &&
               (read_latency >= READ_LATENCY_MIN) && (read_latency <= READ_LATENCY_MAX);
    endfunction

endpackage

// File: rtl/memory_s_sp_clear_seq.sv
// Post-reset clear sequencer: walks every address once, then hands the
// array write port back to the user.
module memory_s_sp_clear_seq
    import memory_sram_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 12,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  busy,
    output logic                  clear_write,
    output logic [ADDR_WIDTH-1:0] clear_address
);

    mem_state_e state;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= CLEAR_ON_RESET ? MEM_STATE_CLEAR : MEM_STATE_READY;
            busy          <= CLEAR_ON_RESET;
            clear_address <= '0;
        end else begin
            case (state)
                MEM_STATE_CLEAR: begin
                    clear_address <= clear_address + ADDR_WIDTH'(1);
                    // Last word written this edge: counter wraps and the port is released.
                    if (clear_address == '1) begin
                        state <= MEM_STATE_READY;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= MEM_STATE_READY;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign clear_write = busy;

endmodule

// File: rtl/memory_s_sp_param_be.sv
// Parametrised synchronous single-port SRAM with byte-lane write enables,
// read-first behaviour, optional output register and post-reset clear.
module memory_s_sp_param_be
    import memory_sram_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 12,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned BYTE_WIDTH     = 8,
    parameter int unsigned READ_LATENCY   = 1,
    parameter bit          CLEAR_ON_RESET = 1'b1,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0,
    localparam int unsigned NUM_BYTES     = DATA_WIDTH / BYTE_WIDTH
) (
    input  logic                  sram_clock,
    input  logic                  sram_reset_n,
    input  logic                  sram_read,
    input  logic                  sram_write,
    input  logic [NUM_BYTES-1:0]  sram_byte_enables,
    input  logic [ADDR_WIDTH-1:0] sram_address,
    input  logic [DATA_WIDTH-1:0] sram_write_data,
    output logic [DATA_WIDTH-1:0] sram_read_data,
    output logic                  sram_read_valid,
    output logic                  sram_busy
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    if (!params_legal(DATA_WIDTH, BYTE_WIDTH, READ_LATENCY)) begin : g_param_check
        $error("memory_s_sp_param_be: illegal DATA_WIDTH/BYTE_WIDTH/READ_LATENCY");
    end

    logic                  busy;
    logic                  clear_write;
    logic [ADDR_WIDTH-1:0] clear_address;

    memory_s_sp_clear_seq #(
        .ADDR_WIDTH     (ADDR_WIDTH),
        .CLEAR_ON_RESET (CLEAR_ON_RESET)
    ) u_clear_seq (
        .clk           (sram_clock),
        .rst_n         (sram_reset_n),
        .busy          (busy),
        .clear_write   (clear_write),
        .clear_address (clear_address)
    );

    logic user_read;
    logic user_write;

    assign user_read  = sram_read  && !busy;
    assign user_write = sram_write && !busy;

    // Single array write port shared by the clear sequencer and the user.
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [NUM_BYTES-1:0]  wr_be;

    always_comb begin
        wr_en   = user_write;
        wr_addr = sram_address;
        wr_data = sram_write_data;
        wr_be   = sram_byte_enables;
        if (clear_write) begin
            wr_en   = 1'b1;
            wr_addr = clear_address;
            wr_data = CLEAR_VALUE;
            wr_be   = '1;
        end
    end

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge sram_clock) begin
        if (wr_en) begin
            for (int unsigned i = 0; i < NUM_BYTES; i++) begin
                if (wr_be[i]) begin
                    mem[wr_addr][i*BYTE_WIDTH +: BYTE_WIDTH] <= wr_data[i*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
        end
    end

    // Read-first: the data register samples the array before this edge's write lands.
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic                  rd_valid_q;

    always_ff @(posedge sram_clock) begin
        if (!sram_reset_n) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= user_read;
            rd_data_q  <= user_read ? mem[sram_address] : '0;
        end
    end

    if (READ_LATENCY == 2) begin : g_out_stage
        logic [DATA_WIDTH-1:0] out_data_q;
        logic                  out_valid_q;

        always_ff @(posedge sram_clock) begin
            if (!sram_reset_n) begin
                out_data_q  <= '0;
                out_valid_q <= 1'b0;
            end else begin
                out_data_q  <= rd_data_q;
                out_valid_q <= rd_valid_q;
            end
        end

        assign sram_read_data  = out_data_q;
        assign sram_read_valid = out_valid_q;
    end else begin : g_no_out_stage
        assign sram_read_data  = rd_data_q;
        assign sram_read_valid = rd_valid_q;
    end

    assign sram_busy = busy;

endmodule
